// File: rtl/period_measure.sv
// Measures the period of asynchronous clk_in in clk cycles; optional averaging via PERIOD_MEASURE_AVG_EN.
// Latency: period_length/period_valid update 1 cycle after the synchronised rise is detected.
// No backpressure: period_valid is a single-cycle strobe, timeout is sticky until the next measurement.
module period_measure #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 1024,
  parameter int AVG_LOG2    = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             PWRDWN,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period_length,
  output logic             period_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [WIDTH-1:0]       cnt_q;
  logic [WIDTH-1:0]       len_q;
  logic                   vld_q;
  logic                   to_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

`ifdef PERIOD_MEASURE_AVG_EN
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int AW    = WIDTH + AVG_LOG2;

  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_sum;
  logic [AVG_LOG2:0] nmeas_q;

  assign acc_sum = acc_q + AW'(cnt_q);
`endif

  always_ff @(posedge clk) begin
    // Power-down holds the block in its reset state; outputs are masked below.
    if (RST || PWRDWN) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef PERIOD_MEASURE_AVG_EN
      acc_q   <= '0;
      nmeas_q <= '0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_q   <= WIDTH'(1);
            state_q <= COUNT;
          end
        end
        COUNT: begin
          // A rise wins over the timeout when both land on MAX_COUNT.
          if (rise) begin
`ifdef PERIOD_MEASURE_AVG_EN
            if (nmeas_q == (AVG_LOG2+1)'(AVG_N - 1)) begin
              len_q   <= WIDTH'(acc_sum >> AVG_LOG2);
              vld_q   <= 1'b1;
              acc_q   <= '0;
              nmeas_q <= '0;
            end else begin
              acc_q   <= acc_sum;
              nmeas_q <= nmeas_q + 1'b1;
            end
`else
            len_q <= cnt_q;
            vld_q <= 1'b1;
`endif
            to_q  <= 1'b0;
            cnt_q <= WIDTH'(1);
          end else if (cnt_q == MAX_CNT) begin
            to_q    <= 1'b1;
            len_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef PERIOD_MEASURE_AVG_EN
            acc_q   <= '0;
            nmeas_q <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period_length = PWRDWN ? {WIDTH{1'bx}} : len_q;
  assign period_valid  = PWRDWN ? 1'bx : vld_q;
  assign timeout       = PWRDWN ? 1'bx : to_q;

endmodule

// File: tb/tb_period_measure.sv
// Directed bench for period_measure: lock, period change, timeout, reset, power-down, alternating periods.
module tb_period_measure;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwrdwn = 1'b0;
  logic             clk_in = 1'b0;
  logic [WIDTH-1:0] period_length;
  logic             period_valid;
  logic             timeout;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobes  = 0;
  int last_len = 0;
  int last_gap = 0;
  int last_stb = 0;
  int snap     = 0;
  int to_cyc   = -1;

  period_measure #(.WIDTH(WIDTH), .SYNC_STAGES(2), .MAX_COUNT(64), .AVG_LOG2(1)) dut (
    .clk           (clk),
    .RST           (rst),
    .PWRDWN        (pwrdwn),
    .clk_in        (clk_in),
    .period_length (period_length),
    .period_valid  (period_valid),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle; outputs sampled 1 ns after the edge, strobes logged.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (period_valid === 1'b1) begin
      strobes++;
      last_len = int'(period_length);
      last_gap = cyc - last_stb;
      last_stb = cyc;
    end
  endtask

  task automatic period(input int n, input int hi);
    clk_in = 1'b1;
    repeat (hi) cycle();
    clk_in = 1'b0;
    repeat (n - hi) cycle();
  endtask

  initial begin
    // Reset state
    repeat (3) cycle();
    check("rst_len", period_length, 0);
    check("rst_vld", period_valid, 0);
    check("rst_to", timeout, 0);
    rst = 1'b0;

    // Basic 20-cycle period: first rise only arms
    period(20, 10);
    check("arm_no_strobe", strobes, 0);
    period(20, 10);
    check("first_strobe", strobes, 1);
    check("first_len", last_len, 20);
    repeat (3) period(20, 10);
    check("basic_cnt", strobes, 4);
    check("basic_len", last_len, 20);
    check("basic_gap", last_gap, 20);
    check("basic_to", timeout, 0);

    // Switch to 10-cycle period: first strobe reports the last 20-cycle span
    period(10, 5);
    check("chg_trans_len", last_len, 20);
    repeat (3) period(10, 5);
    check("chg_len", last_len, 10);
    check("chg_gap", last_gap, 10);

    // Relock at 20 then hold clk_in low until timeout
    period(20, 10);
    check("relock_trans", last_len, 10);
    period(20, 10);
    check("relock_len", last_len, 20);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (timeout === 1'b1) begin
        to_cyc = cyc;
        break;
      end
    end
    check("to_seen", (to_cyc >= 0), 1);
    check("to_delay", ((to_cyc - last_stb) == 64) || ((to_cyc - last_stb) == 65), 1);
    check("to_len", period_length, 0);
    check("to_vld", period_valid, 0);
    snap = strobes;
    period(20, 10);
    check("to_sticky", timeout, 1);
    check("to_rearm_nostb", strobes, snap);
    period(20, 10);
    check("to_clear", timeout, 0);
    check("to_resume_len", last_len, 20);

    // Reset 7 cycles into a period, clk_in low at that moment
    clk_in = 1'b1;
    repeat (5) cycle();
    clk_in = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_len", period_length, 0);
    check("mid_rst_vld", period_valid, 0);
    repeat (12) cycle();
    snap = strobes;
    period(20, 5);
    check("mid_rst_arm", strobes, snap);
    period(20, 5);
    check("mid_rst_strobe", strobes, snap + 1);
    check("mid_rst_len2", last_len, 20);

    // Power-down while locked
    clk_in = 1'b1;
    repeat (5) cycle();
    clk_in = 1'b0;
    pwrdwn = 1'b1;
    repeat (10) cycle();
    check("pd_len_x", period_length, {WIDTH{1'bx}});
    check("pd_vld_x", period_valid, 1'bx);
    check("pd_to_x", timeout, 1'bx);
    pwrdwn = 1'b0;
    cycle();
    check("pd_rel_len", period_length, 0);
    check("pd_rel_vld", period_valid, 0);
    check("pd_rel_to", timeout, 0);
    repeat (4) cycle();
    snap = strobes;
    period(20, 5);
    check("pd_arm", strobes, snap);
    period(20, 5);
    check("pd_len", last_len, 20);

    // Alternating 18/22 periods after a fresh reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    snap = strobes;
    period(18, 9);
    period(22, 11);
    period(18, 9);
    period(22, 11);
`ifdef PERIOD_MEASURE_AVG_EN
    check("alt_cnt_a", strobes - snap, 1);
    check("alt_len_a", last_len, 20);
`else
    check("alt_cnt_a", strobes - snap, 3);
    check("alt_len_a", last_len, 18);
`endif
    period(18, 9);
`ifdef PERIOD_MEASURE_AVG_EN
    check("alt_cnt_b", strobes - snap, 2);
    check("alt_len_b", last_len, 20);
`else
    check("alt_cnt_b", strobes - snap, 4);
    check("alt_len_b", last_len, 22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
